// File: rtl/afu_rd_req_tracker.sv
// Bulk read-request engine: splits a (base, len) command into per-line SPL reads,
// caps outstanding requests, and forwards tagged responses to the AFU.
module afu_rd_req_tracker #(
  parameter int MAX_OUTSTANDING = 32,
  parameter int TAG_W           = 14,
  parameter int ADDR_W          = 42,
  parameter int LEN_W           = 16
) (
  input  logic               vl_clk_LPdomain_32ui,
  input  logic               ffs_vl_LP32ui_lp2sy_SystemReset_n,
  input  logic               spl_enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               spl_tx_rd_almostfull,
  output logic               afu_tx_rd_valid,
  output logic [98:0]        afu_tx_rd_hdr,
  input  logic               spl_rx_rd_valid,
  input  logic [23:0]        spl_rx_hdr0,
  input  logic [511:0]       spl_rx_data,
  output logic               rd_data_valid,
  output logic [511:0]       rd_data,
  output logic [LEN_W-1:0]   rd_data_idx,
  output logic               busy,
  output logic               done
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  ret_cnt;
  logic [OUT_W-1:0]  outstanding;
  logic              stray_err;

  logic              can_issue;
  logic              rsp_take;
  logic              ret_last;
  logic [TAG_W-1:0]  issue_tag;
  logic [TAG_W-1:0]  rsp_tag;
  logic [ADDR_W-1:0] issue_addr;
  logic              unused_bits;

  function automatic logic [98:0] make_hdr(input logic [ADDR_W-1:0] addr,
                                           input logic [TAG_W-1:0]  tag);
    logic [98:0] h;
    h                  = '0;
    h[TAG_W +: ADDR_W] = addr;
    h[TAG_W-1:0]       = tag;
    return h;
  endfunction

  assign issue_tag  = TAG_W'(issue_cnt);
  assign issue_addr = base_addr + ADDR_W'(issue_cnt);
  assign rsp_tag    = spl_rx_hdr0[TAG_W-1:0];

  assign can_issue = (state == ISSUE) && spl_enable && !spl_tx_rd_almostfull &&
                     (outstanding < OUT_W'(MAX_OUTSTANDING)) && (issue_cnt < len_q);
  // Responses only count while a command is live; anything in IDLE is stray.
  assign rsp_take  = (state != IDLE) && spl_rx_rd_valid;
  assign ret_last  = (ret_cnt == len_q) ||
                     (rsp_take && (ret_cnt == len_q - LEN_W'(1)));

  assign unused_bits = ^{stray_err, spl_rx_hdr0[23:TAG_W]};

  always_ff @(posedge vl_clk_LPdomain_32ui or negedge ffs_vl_LP32ui_lp2sy_SystemReset_n) begin
    if (!ffs_vl_LP32ui_lp2sy_SystemReset_n) begin
      state           <= IDLE;
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      afu_tx_rd_valid <= 1'b0;
      afu_tx_rd_hdr   <= '0;
      rd_data_valid   <= 1'b0;
      rd_data         <= '0;
      rd_data_idx     <= '0;
      base_addr       <= '0;
      len_q           <= '0;
      issue_cnt       <= '0;
      ret_cnt         <= '0;
      outstanding     <= '0;
      stray_err       <= 1'b0;
    end else begin
      // Stage p1: registered request and response outputs
      afu_tx_rd_valid <= can_issue;
      rd_data_valid   <= rsp_take;
      done            <= 1'b0;

      if (can_issue) begin
        afu_tx_rd_hdr <= make_hdr(issue_addr, issue_tag);
        issue_cnt     <= issue_cnt + LEN_W'(1);
      end

      if (rsp_take) begin
        rd_data     <= spl_rx_data;
        rd_data_idx <= LEN_W'(rsp_tag);
        ret_cnt     <= ret_cnt + LEN_W'(1);
      end

      if (can_issue && !rsp_take)
        outstanding <= outstanding + OUT_W'(1);
      else if (!can_issue && rsp_take)
        outstanding <= outstanding - OUT_W'(1);

      if ((state == IDLE) && spl_rx_rd_valid)
        stray_err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            base_addr   <= cmd_addr;
            len_q       <= cmd_len;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= (cmd_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (can_issue && (issue_cnt == len_q - LEN_W'(1)))
            state <= DRAIN;
        end
        DRAIN: begin
          if (ret_last)
            state <= DONE;
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afu_rd_req_tracker.sv
// Scoreboard bench for afu_rd_req_tracker: default-cap instance plus a cap-4 instance.
module tb_afu_rd_req_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          spl_enable, cmd_valid, af, rx_valid, use_cap4;
  logic [41:0]   cmd_addr;
  logic [15:0]   cmd_len;
  logic [23:0]   rx_hdr;
  logic [511:0]  rx_data;

  logic          b_cmd_ready, b_tx_valid, b_rd_valid, b_busy, b_done;
  logic [98:0]   b_hdr;
  logic [511:0]  b_rd_data;
  logic [15:0]   b_idx;
  logic          c_cmd_ready, c_tx_valid, c_rd_valid, c_busy, c_done;
  logic [98:0]   c_hdr;
  logic [511:0]  c_rd_data;
  logic [15:0]   c_idx;

  logic          m_cmd_ready, m_tx_valid, m_rd_valid, m_busy, m_done;
  logic [98:0]   m_hdr;
  logic [511:0]  m_rd_data;
  logic [15:0]   m_idx;

  assign m_cmd_ready = use_cap4 ? c_cmd_ready : b_cmd_ready;
  assign m_tx_valid  = use_cap4 ? c_tx_valid  : b_tx_valid;
  assign m_rd_valid  = use_cap4 ? c_rd_valid  : b_rd_valid;
  assign m_busy      = use_cap4 ? c_busy      : b_busy;
  assign m_done      = use_cap4 ? c_done      : b_done;
  assign m_hdr       = use_cap4 ? c_hdr       : b_hdr;
  assign m_rd_data   = use_cap4 ? c_rd_data   : b_rd_data;
  assign m_idx       = use_cap4 ? c_idx       : b_idx;

  afu_rd_req_tracker u_dut (
    .vl_clk_LPdomain_32ui              (clk),
    .ffs_vl_LP32ui_lp2sy_SystemReset_n (rst_n),
    .spl_enable                        (spl_enable),
    .cmd_valid                         (cmd_valid),
    .cmd_ready                         (b_cmd_ready),
    .cmd_addr                          (cmd_addr),
    .cmd_len                           (cmd_len),
    .spl_tx_rd_almostfull              (af),
    .afu_tx_rd_valid                   (b_tx_valid),
    .afu_tx_rd_hdr                     (b_hdr),
    .spl_rx_rd_valid                   (rx_valid),
    .spl_rx_hdr0                       (rx_hdr),
    .spl_rx_data                       (rx_data),
    .rd_data_valid                     (b_rd_valid),
    .rd_data                           (b_rd_data),
    .rd_data_idx                       (b_idx),
    .busy                              (b_busy),
    .done                              (b_done)
  );

  afu_rd_req_tracker #(.MAX_OUTSTANDING(4)) u_dut_cap4 (
    .vl_clk_LPdomain_32ui              (clk),
    .ffs_vl_LP32ui_lp2sy_SystemReset_n (rst_n),
    .spl_enable                        (spl_enable),
    .cmd_valid                         (cmd_valid),
    .cmd_ready                         (c_cmd_ready),
    .cmd_addr                          (cmd_addr),
    .cmd_len                           (cmd_len),
    .spl_tx_rd_almostfull              (af),
    .afu_tx_rd_valid                   (c_tx_valid),
    .afu_tx_rd_hdr                     (c_hdr),
    .spl_rx_rd_valid                   (rx_valid),
    .spl_rx_hdr0                       (rx_hdr),
    .spl_rx_data                       (rx_data),
    .rd_data_valid                     (c_rd_valid),
    .rd_data                           (c_rd_data),
    .rd_data_idx                       (c_idx),
    .busy                              (c_busy),
    .done                              (c_done)
  );

  typedef struct packed { logic [41:0] addr; logic [13:0] tag; } req_t;
  typedef struct packed { logic [15:0] idx; logic [511:0] data; } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  req_t er;
  rsp_t ers;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_req, n_rdv, n_done, win_hits, win_lo, win_hi;
  int acc_cyc, first_req_cyc, last_req_cyc, last_rdv_cyc, done_cyc;
  logic        done_busy, done_ready;
  logic [13:0] last_tag;
  logic [41:0] last_addr;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mkdata(input logic [13:0] t);
    return {16{16'hA5A5, 2'b01, t}};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_tx_valid) begin
      n_req++;
      last_tag  = m_hdr[13:0];
      last_addr = m_hdr[55:14];
      if (n_req == 1) first_req_cyc = cyc;
      last_req_cyc = cyc;
      if (cyc >= win_lo && cyc <= win_hi) win_hits++;
      if (exp_req_q.size() == 0)
        check("req_unexpected", 512'(exp_req_q.size()), 512'(1));
      else begin
        er = exp_req_q.pop_front();
        check("req_addr", 512'(m_hdr[55:14]), 512'(er.addr));
        check("req_tag", 512'(m_hdr[13:0]), 512'(er.tag));
        check("req_hdr_pad", 512'(m_hdr[98:56]), 512'(0));
      end
    end
    if (m_rd_valid) begin
      n_rdv++;
      last_rdv_cyc = cyc;
      if (exp_rsp_q.size() == 0)
        check("rsp_unexpected", 512'(exp_rsp_q.size()), 512'(1));
      else begin
        ers = exp_rsp_q.pop_front();
        check("rsp_idx", 512'(m_idx), 512'(ers.idx));
        check("rsp_data", m_rd_data, ers.data);
      end
    end
    if (m_done) begin
      n_done++;
      done_cyc   = cyc;
      done_busy  = m_busy;
      done_ready = m_cmd_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_req = 0; n_rdv = 0; n_done = 0; win_hits = 0;
    win_lo = 0; win_hi = -1;
    exp_req_q.delete();
    exp_rsp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_mon();
  endtask

  task automatic send_cmd(input logic [41:0] a, input logic [15:0] l);
    req_t r;
    int   b;
    b = 0;
    while (!m_cmd_ready && b < 50) begin tick(1); b++; end
    check("cmd_ready_pre", 512'(m_cmd_ready), 512'(1));
    for (int i = 0; i < int'(l); i++) begin
      r.addr = a + 42'(i);
      r.tag  = 14'(i);
      exp_req_q.push_back(r);
    end
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_drive(input logic [13:0] t, input bit expect_fwd);
    rsp_t e;
    rx_valid = 1'b1;
    rx_hdr   = {10'h2A5, t};
    rx_data  = mkdata(t);
    if (expect_fwd) begin
      e.idx  = 16'(t);
      e.data = mkdata(t);
      exp_rsp_q.push_back(e);
    end
    tick(1);
  endtask

  task automatic rsp_idle();
    rx_valid = 1'b0;
  endtask

  task automatic wait_req(input int n, input int budget);
    int b;
    b = 0;
    while (n_req < n && b < budget) begin tick(1); b++; end
    check("wait_req", 512'(n_req), 512'(n));
  endtask

  task automatic wait_done(input string name, input int budget);
    int b;
    b = 0;
    while (n_done == 0 && b < budget) begin tick(1); b++; end
    check(name, 512'(n_done), 512'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; use_cap4 = 1'b0; spl_enable = 1'b1; cmd_valid = 1'b0;
    cmd_addr = '0; cmd_len = '0; af = 1'b0; rx_valid = 1'b0; rx_hdr = '0; rx_data = '0;
    clear_mon();
    tick(2);
    check("rst_cmd_ready", 512'(m_cmd_ready), 512'(1));
    check("rst_busy", 512'(m_busy), 512'(0));
    check("rst_done", 512'(m_done), 512'(0));
    check("rst_tx_valid", 512'(m_tx_valid), 512'(0));
    check("rst_hdr", 512'(m_hdr), 512'(0));
    check("rst_rd_valid", 512'(m_rd_valid), 512'(0));
    check("rst_rd_data", m_rd_data, 512'(0));
    check("rst_idx", 512'(m_idx), 512'(0));
    rst_n = 1'b1;
    tick(1);

    // Basic command, out-of-order responses
    clear_mon();
    send_cmd(42'h100, 16'd4);
    wait_req(4, 20);
    check("t1_first_lat", 512'(first_req_cyc - acc_cyc), 512'(2));
    check("t1_consec", 512'(last_req_cyc - first_req_cyc), 512'(3));
    check("t1_busy", 512'(m_busy), 512'(1));
    check("t1_ready_low", 512'(m_cmd_ready), 512'(0));
    rsp_drive(14'd2, 1'b1);
    rsp_drive(14'd0, 1'b1);
    rsp_drive(14'd3, 1'b1);
    rsp_drive(14'd1, 1'b1);
    rsp_idle();
    wait_done("t1_done", 20);
    check("t1_done_lat", 512'(done_cyc - last_rdv_cyc), 512'(1));
    check("t1_done_busy", 512'(done_busy), 512'(0));
    check("t1_done_ready", 512'(done_ready), 512'(1));
    tick(3);
    check("t1_done_once", 512'(n_done), 512'(1));
    check("t1_rsp_count", 512'(n_rdv), 512'(4));

    // Outstanding cap of 4
    use_cap4 = 1'b1;
    do_reset();
    send_cmd(42'h40, 16'd10);
    tick(20);
    check("t2_stall", 512'(n_req), 512'(4));
    rsp_drive(14'd1, 1'b1);
    rsp_idle();
    tick(10);
    check("t2_one_more", 512'(n_req), 512'(5));
    check("t2_tag4", 512'(last_tag), 512'(4));
    rsp_drive(14'd2, 1'b1);
    rsp_drive(14'd3, 1'b1);
    rsp_idle();
    tick(10);
    check("t2_net_zero", 512'(n_req), 512'(7));
    check("t2_tag6", 512'(last_tag), 512'(6));
    check("t2_rsp_count", 512'(n_rdv), 512'(3));

    // almostfull window
    use_cap4 = 1'b0;
    do_reset();
    send_cmd(42'h1000, 16'd8);
    win_lo = acc_cyc + 4;
    win_hi = acc_cyc + 8;
    tick(2);
    af = 1'b1;
    tick(5);
    af = 1'b0;
    wait_req(8, 30);
    check("t3_window_quiet", 512'(win_hits), 512'(0));
    check("t3_last_tag", 512'(last_tag), 512'(7));
    for (int i = 0; i < 8; i++) rsp_drive(14'(i), 1'b1);
    rsp_idle();
    wait_done("t3_done", 20);
    win_lo = 0; win_hi = -1;

    // Zero-length command
    clear_mon();
    send_cmd(42'h300, 16'd0);
    wait_done("t4_done", 10);
    check("t4_done_lat", 512'(done_cyc - acc_cyc), 512'(2));
    check("t4_done_ready", 512'(done_ready), 512'(1));
    tick(3);
    check("t4_no_req", 512'(n_req), 512'(0));

    // Reset mid-command, then stray response, then fresh command
    clear_mon();
    send_cmd(42'h500, 16'd6);
    begin
      int b;
      b = 0;
      while (n_req < 3 && b < 20) begin @(negedge clk); #1; b++; end
    end
    rst_n = 1'b0;
    #1;
    check("t5_req3", 512'(n_req), 512'(3));
    check("t5_rst_tx_valid", 512'(m_tx_valid), 512'(0));
    check("t5_rst_hdr", 512'(m_hdr), 512'(0));
    check("t5_rst_busy", 512'(m_busy), 512'(0));
    check("t5_rst_ready", 512'(m_cmd_ready), 512'(1));
    check("t5_rst_rd_data", m_rd_data, 512'(0));
    exp_req_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("t5_no_req_after_rst", 512'(n_req), 512'(3));
    rsp_drive(14'd1, 1'b0);
    rsp_idle();
    tick(3);
    check("t5_stray_fwd", 512'(n_rdv), 512'(0));
    check("t5_stray_idle", 512'(m_busy), 512'(0));
    clear_mon();
    send_cmd(42'h200, 16'd2);
    wait_req(2, 20);
    check("t5_last_tag", 512'(last_tag), 512'(1));
    rsp_drive(14'd0, 1'b1);
    rsp_drive(14'd1, 1'b1);
    rsp_idle();
    wait_done("t5_done", 20);

    // Address wrap at 2^42
    clear_mon();
    send_cmd(42'h3FF_FFFF_FFFE, 16'd3);
    wait_req(3, 20);
    check("t6_wrap_addr", 512'(last_addr), 512'(0));
    for (int i = 0; i < 3; i++) rsp_drive(14'(i), 1'b1);
    rsp_idle();
    wait_done("t6_done", 20);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
